// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// Op encodings, FSM state type and counter width.
package md_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_e;

endpackage

// File: rtl/md_scheduler_if.sv
// E/D-stage to MDU bundle: op request, D-stage HI/LO use,
// busy/stall back to the pipeline and architectural HI/LO.
interface md_scheduler_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, md_use_d,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, md_use_d,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_scheduler_arith.sv
// Combinational 64-bit MDU result: {hi, lo} for mult/div ops.
// Ports: op, a, b in; result (hi:lo) and div_zero flag out.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] smul;
    logic [63:0] umul;

    // Divide on magnitudes, then fix signs: quotient truncates
    // toward zero, remainder follows the dividend. INT_MIN/-1
    // wraps back to INT_MIN with remainder 0 on its own.
    always_comb begin
        sgn    = (op == MD_DIV);
        a_neg  = sgn & a[31];
        b_neg  = sgn & b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        div_zero = (b == 32'd0);
        b_safe = div_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r      = a_neg ? (32'd0 - r_mag) : r_mag;
        smul   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul   = {32'd0, a} * {32'd0, b};
        result = 64'd0;
        case (op)
            MD_MULT:  result = smul;
            MD_MULTU: result = umul;
            MD_DIV,
            MD_DIVU:  result = {r, q};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// MDU scheduler: fixed-latency mult/div sequencing, HI/LO regs
// and D-stage stall request. Ports: clk, reset_n, md (slave).
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    md_scheduler_if.slave  md
);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_pend;
    logic [31:0]      lo_pend;
    logic             dz_pend;
    logic [63:0]      res;
    logic             res_dz;
    logic             start_acc;

    md_arith u_arith (
        .op       (md.op),
        .a        (md.src_a),
        .b        (md.src_b),
        .result   (res),
        .div_zero (res_dz)
    );

    assign start_acc   = md.start & (state == MD_IDLE);
    assign md.stall_md = md.md_use_d & (busy_q | start_acc);
    assign md.busy     = busy_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
            dz_pend <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start_acc) begin
                        case (md.op)
                            MD_MULT, MD_MULTU: begin
                                hi_pend <= res[63:32];
                                lo_pend <= res[31:0];
                                dz_pend <= 1'b0;
                                cnt     <= CNT_W'(MULT_CYCLES - 1);
                                busy_q  <= 1'b1;
                                state   <= MD_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                hi_pend <= res[63:32];
                                lo_pend <= res[31:0];
                                dz_pend <= res_dz;
                                cnt     <= CNT_W'(DIV_CYCLES - 1);
                                busy_q  <= 1'b1;
                                state   <= MD_RUN;
                            end
                            MD_MTHI: hi_q <= md.src_a;
                            MD_MTLO: lo_q <= md.src_a;
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    if (cnt == '0) begin
                        // Divide by zero leaves HI/LO untouched.
                        if (!dz_pend) begin
                            hi_q <= hi_pend;
                            lo_q <= lo_pend;
                        end
                        busy_q <= 1'b0;
                        state  <= MD_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide unit (MDU) scheduler for the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and holds the HI/LO registers. It sequences fixed-latency multiply/divide operations with a busy counter. It raises a stall request to the hazard/stall logic whenever the D-stage instruction touches HI/LO while an operation is pending.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1-15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1-15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: E-stage instruction is an MDU op, valid this cycle.
- `op`, input, 3: operation code, one of the `md_pkg` encodings.
- `src_a`, input, 32: rs value after forwarding.
- `src_b`, input, 32: rt value after forwarding.
- `md_use_d`, input, 1: D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- `busy`, output, 1: an operation is in progress.
- `stall_md`, output, 1: stall request to the pipeline, equal to `md_use_d & (busy | start_accepted)`.
- `hi`, output, 32: architectural HI.
- `lo`, output, 32: architectural LO.

## Operation
- States: IDLE and RUN. Reset forces IDLE, `busy`=0, counter=0, `hi`=0, `lo`=0.
- `start_accepted = start & (state == IDLE)`.
- `start` while in RUN is ignored. No state change occurs. This case cannot occur when the stall is honoured.
- IDLE with `start_accepted`:
  - MULT/MULTU/DIV/DIVU: compute the 64-bit result from `src_a`/`src_b` and latch it into the pending HI/LO registers. Load the counter with `MULT_CYCLES`-1 or `DIV_CYCLES`-1. Go to RUN.
  - MTHI/MTLO: write `src_a` to `hi` or `lo` at this edge. Stay in IDLE. `busy` is never raised.
  - Any other `op` code: ignored.
- RUN: decrement the counter each cycle. On the edge where counter==0, commit pending HI/LO to `hi`/`lo` and go to IDLE.
- Arithmetic:
  - MULT is a signed 32x32->64 multiply. MULTU is unsigned. HI = bits 63:32, LO = bits 31:0.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: the op still runs the full `DIV_CYCLES`. `hi`/`lo` keep their previous values at commit.
- MFHI/MFLO are not handled here. The E-stage read uses `hi`/`lo` directly. The stall guarantees they are committed before use.

## Timing
- `start` sampled at edge t: `busy`=1 for cycles t+1 .. t+N, where N is the op's cycle count. `hi`/`lo` change at edge t+N. `busy`=0 from t+N.
- `stall_md` is combinational. It is already high in cycle t if `md_use_d`=1, because `start_accepted` contributes.
- A back-to-back MDU op in D is therefore stalled N+1 cycles, counting cycle t. It proceeds in the first cycle with `busy`=0.
- MTHI/MTLO: `hi`/`lo` update at edge t. Latency 1, no stall contribution after t.
- Async reset during RUN: the operation is abandoned immediately. Outputs return to reset values without waiting for a clock. The pending result is discarded.

## Structure
- Package `md_pkg`:
  - `op` encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State enum.
  - Counter width constant of 4 bits.
- Sub-module `md_arith`: combinational 64-bit result generator, covering signed/unsigned multiply, divide, the divide-by-zero flag and the INT_MIN/-1 case.
- Top level holds the FSM, counter, pending and architectural HI/LO registers, and the stall equation.

## Test plan
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007), start at edge t:
  - `busy` high exactly 5 cycles.
  - At edge t+5, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU 100/7:
  - `busy` high 10 cycles.
  - Then LO=14, HI=2.
- DIV -7/2:
  - LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide by zero:
  - Preload HI=0x11 and LO=0x22 via MTHI/MTLO, each with 1-cycle latency and `busy` never set.
  - DIV x/0 runs 10 cycles, after which HI=0x11 and LO=0x22 are unchanged.
- Stall with a second request:
  - `md_use_d`=1 in the same cycle as a MULT start: `stall_md`=1 for 6 consecutive cycles, then 0.
  - A `start` pulsed during RUN has no effect on the counter or the result.
- Reset mid-operation:
  - Deassert `reset_n` in the 3rd busy cycle of a DIV: `busy`, `hi` and `lo` are 0 immediately.
  - After release, state is IDLE and the next MULT completes normally.
